iomem_gpio: RTL

- Parametrised GPIO peripheral on the PicoSoC iomem bus.
- Successor to the fixed 8-LED/8-switch decode in the board top. Adds:
  - configurable input/output widths and base address
  - input synchronisation
  - atomic set/clear of outputs
  - per-bit edge-detect interrupts with selectable polarity
- Instantiated in board tops beside picosoc_noflash. Its irq drives one of irq_5..irq_7.

---
 rtl/iomem_gpio_pkg.sv | 24 ++
 rtl/iomem_gpio_if.sv | 14 +
 rtl/iomem_gpio_in_sync.sv | 33 +++
 rtl/iomem_gpio.sv | 114 +++++++++++
 4 files changed

// File: rtl/iomem_gpio_pkg.sv
// Shared constants and helpers for the iomem GPIO peripheral.
// Register offsets are word indices taken from iomem_addr[7:2].
package iomem_gpio_pkg;

  localparam logic [5:0] REG_OUT      = 6'h00;
  localparam logic [5:0] REG_IN       = 6'h01;
  localparam logic [5:0] REG_IRQ_EN   = 6'h02;
  localparam logic [5:0] REG_IRQ_EDGE = 6'h03;
  localparam logic [5:0] REG_IRQ_STAT = 6'h04;
  localparam logic [5:0] REG_OUT_SET  = 6'h05;
  localparam logic [5:0] REG_OUT_CLR  = 6'h06;

  // Replace the strobed bytes of old_v with the matching bytes of wdata.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoSoC iomem bus bundle: the CPU side is master, peripherals are slaves.
interface iomem_gpio_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/iomem_gpio_in_sync.sv
// Multi-flop synchroniser for asynchronous pins plus a previous-value
// flop so rising and falling events can be flagged per bit.
module gpio_in_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= din_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = ~prev_q &  sync_q[STAGES-1];
  assign fall_o =  prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: strobed output register with
// atomic set/clear, synchronised inputs and per-bit edge interrupts.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter logic [7:0] ADDR_BASE   = 8'h03,
  parameter int         NUM_IN      = 8,
  parameter int         NUM_OUT     = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  iomem_gpio_if.slave        bus,
  input  logic [NUM_IN-1:0]  gpio_in,
  output logic [NUM_OUT-1:0] gpio_out,
  output logic               irq
);

  logic [NUM_IN-1:0]  in_sync, in_rise, in_fall, evt;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic [NUM_IN-1:0]  en_q, en_d, edg_q, edg_d, stat_q, stat_d;
  logic               ready_q, done_q, irq_q;
  logic [31:0]        rdata_q, rdata_d, rd_val;
  logic [31:0]        wbits, out_wr, en_wr, edg_wr;
  logic               sel, wr;
  logic [5:0]         off;

  gpio_in_sync #(.WIDTH(NUM_IN), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .din_i  (gpio_in),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

  assign off = bus.iomem_addr[7:2];
  // done_q blocks a second ack while the master keeps the same request valid.
  assign sel = bus.iomem_valid && !ready_q && !done_q &&
               (bus.iomem_addr[31:24] == ADDR_BASE);
  assign wr  = sel && (bus.iomem_wstrb != 4'h0);

  assign wbits  = strb_merge(32'h0, bus.iomem_wdata, bus.iomem_wstrb);
  assign out_wr = strb_merge(32'(out_q), bus.iomem_wdata, bus.iomem_wstrb);
  assign en_wr  = strb_merge(32'(en_q),  bus.iomem_wdata, bus.iomem_wstrb);
  assign edg_wr = strb_merge(32'(edg_q), bus.iomem_wdata, bus.iomem_wstrb);

  assign evt = (in_rise & ~edg_q) | (in_fall & edg_q);

  always_comb begin
    rd_val = 32'h0;
    case (off)
      REG_OUT:      rd_val = 32'(out_q);
      REG_IN:       rd_val = 32'(in_sync);
      REG_IRQ_EN:   rd_val = 32'(en_q);
      REG_IRQ_EDGE: rd_val = 32'(edg_q);
      REG_IRQ_STAT: rd_val = 32'(stat_q);
      default:      rd_val = 32'h0;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    en_d    = en_q;
    edg_d   = edg_q;
    stat_d  = stat_q;
    rdata_d = sel ? rd_val : rdata_q;
    if (wr) begin
      case (off)
        REG_OUT:      out_d  = out_wr[NUM_OUT-1:0];
        REG_IRQ_EN:   en_d   = en_wr[NUM_IN-1:0];
        REG_IRQ_EDGE: edg_d  = edg_wr[NUM_IN-1:0];
        REG_IRQ_STAT: stat_d = stat_q & ~wbits[NUM_IN-1:0];
        REG_OUT_SET:  out_d  = out_q | wbits[NUM_OUT-1:0];
        REG_OUT_CLR:  out_d  = out_q & ~wbits[NUM_OUT-1:0];
        default:      ;
      endcase
    end
    // A new event overrides a same-cycle W1C.
    stat_d = stat_d | evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      en_q    <= '0;
      edg_q   <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      en_q    <= en_d;
      edg_q   <= edg_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
      ready_q <= sel;
      done_q  <= sel | (done_q & bus.iomem_valid);
      irq_q   <= |(stat_q & en_q);
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign gpio_out        = out_q;
  assign irq             = irq_q;

  logic unused_ok;
  assign unused_ok = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0],
                       wbits, out_wr, en_wr, edg_wr};

endmodule
